rf_wb_arbiter: RTL

//  Owns the single byte-enabled write port of the GPR file; shares it between the in-order

---
 rtl/rf_wb_arbiter_pkg.sv | 23 ++
 rtl/rf_wb_arbiter_ld_skid.sv | 35 +++
 rtl/rf_wb_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, write-request payload and helpers for the GPR write-port arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned NREG       = 32;
  localparam int unsigned AW         = 5;
  localparam int unsigned DW         = 32;
  localparam int unsigned BE_W       = DW / 8;
  localparam int unsigned STARVE_MAX = 3;
  localparam int unsigned SW         = $clog2(STARVE_MAX + 1);

  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [BE_W-1:0] we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
  } wr_req_t;

  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_ld_skid.sv
// One-entry load-return buffer: accepts only when empty, empties on drain.
module rf_wb_arbiter_ld_skid
  import rf_wb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_valid,
  output logic    o_ready,
  input  wr_req_t i_req,
  input  logic    i_drain,
  output logic    o_full,
  output wr_req_t o_req
);

  logic    r_full;
  wr_req_t r_req;

  // Fill and drain never coincide: fill needs empty, drain needs full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_req  <= '0;
    end else if (i_valid && !r_full) begin
      r_full <= 1'b1;
      r_req  <= i_req;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_ready = ~r_full;
  assign o_full  = r_full;
  assign o_req   = r_req;

endmodule

// File: rtl/rf_wb_arbiter.sv
// GPR write-port arbiter: WB pipe vs buffered load returns, with starvation
// guard and a pending-load scoreboard for decode stalls.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_valid,
  output logic            pipe_ready,
  input  logic [BE_W-1:0] pipe_we,
  input  logic [AW-1:0]   pipe_waddr,
  input  logic [DW-1:0]   pipe_wdata,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_issue_addr,
  output logic            ld_issue_rdy,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [BE_W-1:0] ld_we,
  input  logic [AW-1:0]   ld_waddr,
  input  logic [DW-1:0]   ld_wdata,
  input  logic [AW-1:0]   chk_addr1,
  input  logic [AW-1:0]   chk_addr2,
  output logic            chk_busy,
  output logic            ld_err,
  output logic [BE_W-1:0] rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata
);

  logic            w_full;
  logic            w_pipe_use;
  logic            w_at_max;
  logic            w_drain;
  logic            w_clr_hit;
  logic            w_set;
  wr_req_t         w_ld_req;
  wr_req_t         w_buf;
  wr_req_t         w_sel;
  logic [SW-1:0]   r_starve;
  logic [NREG-1:0] r_pend;
  logic            r_ld_err;

  assign w_ld_req = '{we: ld_we, waddr: ld_waddr, wdata: ld_wdata};

  rf_wb_arbiter_ld_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_valid (ld_valid),
    .o_ready (ld_ready),
    .i_req   (w_ld_req),
    .i_drain (w_drain),
    .o_full  (w_full),
    .o_req   (w_buf)
  );

  // A we=0000 pipe beat needs no port, so it never blocks the buffer.
  assign w_pipe_use = pipe_valid & (|pipe_we);
  assign w_at_max   = (r_starve == SW'(STARVE_MAX));
  assign w_drain    = w_full & (~w_pipe_use | w_at_max);
  assign pipe_ready = ~(w_full & w_pipe_use & w_at_max);

  always_comb begin
    w_sel = '0;
    if (w_drain)
      w_sel = w_buf;
    else if (w_pipe_use)
      w_sel = '{we: pipe_we, waddr: pipe_waddr, wdata: pipe_wdata};
  end

  assign rf_we    = is_zero_reg(w_sel.waddr) ? '0 : w_sel.we;
  assign rf_waddr = w_sel.waddr;
  assign rf_wdata = w_sel.wdata;

  // Starvation count only advances while a full buffer loses to the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_starve <= '0;
    else if (!w_full || w_drain)
      r_starve <= '0;
    else
      r_starve <= r_starve + SW'(1);
  end

  assign w_clr_hit    = w_drain & (w_buf.waddr == ld_issue_addr);
  assign ld_issue_rdy = is_zero_reg(ld_issue_addr) | ~r_pend[ld_issue_addr] | w_clr_hit;
  assign w_set        = ld_issue & ld_issue_rdy & ~is_zero_reg(ld_issue_addr);

  // Later assignment wins, so a same-cycle re-issue keeps the register pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      if (w_drain)
        r_pend[w_buf.waddr] <= 1'b0;
      if (w_set)
        r_pend[ld_issue_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ld_err <= 1'b0;
    else if (w_drain && !is_zero_reg(w_buf.waddr) && !r_pend[w_buf.waddr])
      r_ld_err <= 1'b1;
  end

  assign ld_err   = r_ld_err;
  assign chk_busy = (~is_zero_reg(chk_addr1) & r_pend[chk_addr1]) |
                    (~is_zero_reg(chk_addr2) & r_pend[chk_addr2]);

endmodule
